// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the byte-addressed LC-3 main memory between the
// instruction fetch port (F, word reads only) and the data port (D, byte/word
// read/write). Each access holds mem_en for WAIT_STATES+1 cycles and is then
// acknowledged with a one-cycle rdy pulse. Ties alternate, starting with D.
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd-address word accesses skip
// the memory and complete immediately with a fault pulse).
module lc3_mem_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_rdy,
  output logic [15:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              d_rdy,
  output logic [15:0]       d_rdata,
  output logic              fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic       PORT_F = 1'b0;
  localparam logic       PORT_D = 1'b1;
  localparam logic [3:0] WS_C   = 4'(WAIT_STATES);

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;

  // latched request of the port currently being served
  logic                last_grant_r;
  logic                gnt_r;
  logic                we_r;
  logic                size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [15:0]         wdata_r;
  logic                mis_r;

  // arbitration decision (only acted on in IDLE)
  logic                pick_any_s;
  logic                pick_d_s;
  logic                grant_s;
  logic                sel_we_s;
  logic                sel_size_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [15:0]         sel_wdata_s;
  logic                misaligned_s;

  // request fields as they will be after the coming edge
  logic                gnt_nxt_s;
  logic                we_nxt_s;
  logic                size_nxt_s;
  logic [ADDR_W-1:0]   addr_nxt_s;
  logic [15:0]         wdata_nxt_s;
  logic                mis_nxt_s;

  // next values of the registered outputs
  logic                f_rdy_nxt_s, d_rdy_nxt_s, fault_nxt_s;
  logic                mem_en_nxt_s, mem_we_nxt_s, mem_size_nxt_s, busy_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_nxt_s;
  logic [15:0]         mem_wdata_nxt_s;

  logic                f_rdy_r, d_rdy_r, fault_r;
  logic                mem_en_r, mem_we_r, mem_size_r, busy_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [15:0]         mem_wdata_r;
  logic [15:0]         f_rdata_r, d_rdata_r;

  // D wins when alone, or on a tie when F was served last
  assign pick_any_s  = f_req | d_req;
  assign pick_d_s    = d_req & (~f_req | (last_grant_r == PORT_F));
  assign grant_s     = (state_r == ST_IDLE) & pick_any_s;

  // F is always a word read
  assign sel_we_s    = pick_d_s ? d_we    : 1'b0;
  assign sel_size_s  = pick_d_s ? d_size  : 1'b0;
  assign sel_addr_s  = pick_d_s ? d_addr  : f_addr;
  assign sel_wdata_s = pick_d_s ? d_wdata : 16'h0000;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_s = ~sel_size_s & sel_addr_s[0];
`else
  assign misaligned_s = 1'b0;
`endif

  assign gnt_nxt_s   = grant_s ? pick_d_s     : gnt_r;
  assign we_nxt_s    = grant_s ? sel_we_s     : we_r;
  assign size_nxt_s  = grant_s ? sel_size_s   : size_r;
  assign addr_nxt_s  = grant_s ? sel_addr_s   : addr_r;
  assign wdata_nxt_s = grant_s ? sel_wdata_s  : wdata_r;
  assign mis_nxt_s   = grant_s ? misaligned_s : mis_r;

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and wait-counter sequencing
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          cnt_nxt_s   = 4'd0;
          state_nxt_s = misaligned_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == WS_C) begin
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r + 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so the outputs can be registered
  always_comb begin
    mem_en_nxt_s    = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_size_nxt_s  = 1'b0;
    mem_addr_nxt_s  = '0;
    mem_wdata_nxt_s = 16'h0000;
    f_rdy_nxt_s     = 1'b0;
    d_rdy_nxt_s     = 1'b0;
    fault_nxt_s     = 1'b0;
    if (state_nxt_s == ST_ACCESS) begin
      mem_en_nxt_s    = 1'b1;
      mem_we_nxt_s    = we_nxt_s & (cnt_nxt_s == WS_C);
      mem_size_nxt_s  = size_nxt_s;
      mem_addr_nxt_s  = addr_nxt_s;
      mem_wdata_nxt_s = wdata_nxt_s;
    end else begin
      mem_en_nxt_s = 1'b0;
    end
    if (state_nxt_s == ST_DONE) begin
      f_rdy_nxt_s = (gnt_nxt_s == PORT_F);
      d_rdy_nxt_s = (gnt_nxt_s == PORT_D);
      fault_nxt_s = mis_nxt_s;
    end else begin
      fault_nxt_s = 1'b0;
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // Latch the granted request and remember who was served last
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= PORT_F;
      gnt_r        <= PORT_F;
      we_r         <= 1'b0;
      size_r       <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 16'h0000;
      mis_r        <= 1'b0;
    end else if (grant_s) begin
      last_grant_r <= pick_d_s;
      gnt_r        <= pick_d_s;
      we_r         <= sel_we_s;
      size_r       <= sel_size_s;
      addr_r       <= sel_addr_s;
      wdata_r      <= sel_wdata_s;
      mis_r        <= misaligned_s;
    end
  end

  // Registered memory-side and handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_size_r  <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 16'h0000;
      f_rdy_r     <= 1'b0;
      d_rdy_r     <= 1'b0;
      fault_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      mem_en_r    <= mem_en_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_size_r  <= mem_size_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      f_rdy_r     <= f_rdy_nxt_s;
      d_rdy_r     <= d_rdy_nxt_s;
      fault_r     <= fault_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Capture read data in the last ACCESS cycle; a misaligned grant zeroes it
  always_ff @(posedge clk) begin
    if (reset) begin
      f_rdata_r <= 16'h0000;
      d_rdata_r <= 16'h0000;
    end else if ((state_r == ST_ACCESS) && (cnt_r == WS_C) && !we_r) begin
      if (gnt_r == PORT_D) begin
        d_rdata_r <= size_r ? {8'h00, mem_rdata[15:8]} : mem_rdata;
      end else begin
        f_rdata_r <= mem_rdata;
      end
    end else if (grant_s && misaligned_s) begin
      if (pick_d_s) begin
        d_rdata_r <= 16'h0000;
      end else begin
        f_rdata_r <= 16'h0000;
      end
    end
  end

  assign f_rdy     = f_rdy_r;
  assign f_rdata   = f_rdata_r;
  assign d_rdy     = d_rdy_r;
  assign d_rdata   = d_rdata_r;
  assign fault     = fault_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_size  = mem_size_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Testbench for lc3_mem_arbiter: byte-array memory model, directed accesses,
// and a scoreboard of expected rdy responses checked by a separate monitor.
module tb_lc3_mem_arbiter;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, f_rdy, d_req, d_we, d_size, d_rdy, fault;
  logic [15:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, mem_size, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  lc3_mem_arbiter #(.WAIT_STATES(WS), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdy(f_rdy), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdy(d_rdy), .d_rdata(d_rdata), .fault(fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory model; word reads return {mem[a], mem[a+1]}
  bit [7:0]    mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_a  = 16'h0000;
  logic [7:0]  tb_d  = 8'h00;
  logic [15:0] addr_p1;
  assign addr_p1   = mem_addr + 16'd1;
  assign mem_rdata = {mem[mem_addr], mem[addr_p1]};

  // Memory writes: bench preloads, then DUT strobes
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_a] <= tb_d;
    end else if (mem_en && mem_we) begin
      if (mem_size) begin
        mem[mem_addr] <= mem_wdata[7:0];
      end else begin
        mem[mem_addr] <= mem_wdata[15:8];
        mem[addr_p1]  <= mem_wdata[7:0];
      end
    end
  end

  typedef struct packed {
    logic        is_d;
    logic [15:0] rdata;
    logic        fault;
  } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [15:0] rd, input logic flt);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rd;
    e.fault = flt;
    sbq.push_back(e);
  endtask

  // Monitor: every rdy pulse is matched against the front of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (f_rdy || d_rdy) begin
        if (sbq.size() == 0) begin
          chk("rdy_unexpected", {f_rdy, d_rdy}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rdy_port", {f_rdy, d_rdy}, e.is_d ? 32'd1 : 32'd2);
          chk("rdata", d_rdy ? d_rdata : f_rdata, e.rdata);
          chk("fault", fault, e.fault);
        end
      end else if (fault) begin
        chk("fault_stray", fault, 32'd0);
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One access from idle; checks latency, enable/strobe cycles, bus fields
  task automatic access(input logic is_d, input logic we, input logic sz,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic exp_flt,
                        input int exp_lat, input int exp_en);
    int lat, en_c, we_c;
    logic done;
    @(negedge clk);
    push(is_d, exp_rd, exp_flt);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    lat = 0; en_c = 0; we_c = 0; done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_en) begin
        en_c++;
        chk("mem_addr", mem_addr, addr);
        chk("mem_size", mem_size, sz);
      end
      if (mem_we) begin
        we_c++;
        chk("mem_wdata", mem_wdata, wd);
      end
      if (f_rdy || d_rdy) done = 1'b1;
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    chk("rdy_seen", done, 32'd1);
    chk("latency", lat, exp_lat);
    chk("en_cycles", en_c, exp_en);
    chk("we_cycles", we_c, (we && exp_en != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int n, cyc;
    reset = 1'b1;
    f_req = 1'b0; f_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_size = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    @(negedge clk);
    poke(16'h3000, 8'h12); poke(16'h3001, 8'h34);
    poke(16'h4001, 8'h11); poke(16'h4002, 8'hCD);
    poke(16'h5003, 8'h9A); poke(16'h5004, 8'hBC);
    poke(16'hFFFF, 8'h56); poke(16'h0000, 8'h78);
    do_reset();

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ctl", {f_rdy, d_rdy, fault, mem_en, mem_we, mem_size, busy}, 32'd0);
      chk("idle_rdata", {f_rdata, d_rdata}, 32'd0);
      chk("idle_bus", {mem_addr, mem_wdata}, 32'd0);
    end

    // basic fetch, byte write/read, word write/read
    access(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, WS + 2, WS + 1);
    access(1'b1, 1'b1, 1'b1, 16'h4001, 16'h00AB, 16'h0000, 1'b0, WS + 2, WS + 1);
    chk("mem_byte_written", {mem[16'h4000], mem[16'h4001], mem[16'h4002]}, 32'h00ABCD);
    access(1'b1, 1'b0, 1'b1, 16'h4001, 16'h0000, 16'h00AB, 1'b0, WS + 2, WS + 1);
    access(1'b1, 1'b1, 1'b0, 16'h4010, 16'hBEEF, 16'h00AB, 1'b0, WS + 2, WS + 1);
    access(1'b1, 1'b0, 1'b0, 16'h4010, 16'h0000, 16'hBEEF, 1'b0, WS + 2, WS + 1);

    // tie from reset, both held: D, F, D, F
    do_reset();
    @(negedge clk);
    chk("post_reset_rdata", {f_rdata, d_rdata}, 32'd0);
    push(1'b1, 16'hBEEF, 1'b0); push(1'b0, 16'h1234, 1'b0);
    push(1'b1, 16'hBEEF, 1'b0); push(1'b0, 16'h1234, 1'b0);
    f_req = 1'b1; f_addr = 16'h3000;
    d_req = 1'b1; d_we = 1'b0; d_size = 1'b0; d_addr = 16'h4010;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (f_rdy || d_rdy) n++;
    end
    f_req = 1'b0; d_req = 1'b0;
    chk("tie_rdys", n, 32'd4);
    chk("tie_period", cyc, 32'd4 * (WS + 3) - 32'd1);

    // reset during the ACCESS of a D write abandons it
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 1'b0; d_addr = 16'h4020; d_wdata = 16'h5555;
    @(negedge clk);
    chk("abort_in_access", {mem_en, busy}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ctl", {mem_en, mem_we, busy, d_rdy}, 32'd0);
    chk("abort_rdata", {f_rdata, d_rdata}, 32'd0);
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", {mem_we, d_rdy, busy}, 32'd0);
    end
    chk("abort_mem", {mem[16'h4020], mem[16'h4021]}, 32'd0);
    access(1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, WS + 2, WS + 1);

    // misaligned word read, and word access at the top of memory
`ifdef MEM_ALIGN_CHECK_EN
    access(1'b1, 1'b0, 1'b0, 16'h5003, 16'h0000, 16'h0000, 1'b1, 1, 0);
    access(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1, 0);
`else
    access(1'b1, 1'b0, 1'b0, 16'h5003, 16'h0000, 16'h9ABC, 1'b0, WS + 2, WS + 1);
    access(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h5678, 1'b0, WS + 2, WS + 1);
`endif
    // byte read at an odd address is never a fault
    access(1'b1, 1'b0, 1'b1, 16'h5003, 16'h0000, 16'h009A, 1'b0, WS + 2, WS + 1);

    repeat (4) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop if the run ever wedges
  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
